// File: rtl/led_arbiter.sv
// Round-robin arbiter sharing one RGB LED among N_REQ requesters, with a dwell limit.
// Define LED_ARBITER_PREEMPT_EN to let requester 0 preempt any other owner.
module led_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DWELL_TICKS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] color,
  output logic [N_REQ-1:0]   grant,
  output logic [2:0]         rgb,
  output logic               busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(DWELL_TICKS + 1);
  localparam int unsigned NR = N_REQ;
  localparam logic [TW-1:0] EXPIRE = TW'(DWELL_TICKS - 1);
  localparam logic [IW-1:0] LAST   = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_SWITCH = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic [IW-1:0] idx;
  logic [IW-1:0] owner_next;
  logic [TW-1:0] timer;
  logic          found;
  logic          others;
  logic          released;
  logic          expired;
  logic          leave;
`ifdef LED_ARBITER_PREEMPT_EN
  logic          preempt;
`endif

  // Search upward from ptr, wrapping at N_REQ-1; first requester found wins.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    idx   = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = IW'((32'(ptr) + k) % NR);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    owner_next = (owner == LAST) ? '0 : owner + 1'b1;
    others     = |(req & ~grant);
    released   = !req[owner];
    expired    = (timer == EXPIRE) && others;
`ifdef LED_ARBITER_PREEMPT_EN
    preempt    = (owner != '0) && req[0];
    leave      = released || expired || preempt;
`else
    leave      = released || expired;
`endif
  end

  always_comb begin
    case (state)
      S_GRANT:  rgb = color[3*owner +: 3];
      S_IDLE,
      S_SWITCH: rgb = '0;
      default:  rgb = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      timer <= '0;
      owner <= '0;
      grant <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            state <= S_GRANT;
            owner <= sel;
            timer <= '0;
            grant <= N_REQ'(1) << sel;
            busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (leave) begin
            state <= S_SWITCH;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= owner_next;
`ifdef LED_ARBITER_PREEMPT_EN
            if (preempt) ptr <= '0;
`endif
          end else if (timer == EXPIRE) begin
            // Lone requester at dwell limit: restart the dwell and keep the LED.
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_SWITCH: state <= S_IDLE;
        default: begin
          state <= S_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter (N_REQ=4, DWELL_TICKS=8); expectations are queued as
// stimulus is applied and popped one per clock. Honours LED_ARBITER_PREEMPT_EN.
module tb_led_arbiter;
  localparam int N = 4;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [3*N-1:0] color;
  logic [N-1:0]   grant;
  logic [2:0]     rgb;
  logic           busy;

  logic [7:0] exp_q[$];
  logic [2:0] col[N];
  int checks = 0;
  int fails  = 0;
  localparam logic [7:0] BLANK = '0;

  always #5 clk = ~clk;

  led_arbiter #(.N_REQ(N), .DWELL_TICKS(D)) dut (
    .clk(clk), .rst(rst), .req(req), .color(color),
    .grant(grant), .rgb(rgb), .busy(busy)
  );

  // Expected {grant, rgb, busy} while requester i owns the LED.
  function automatic logic [7:0] owned(int i);
    logic [3:0] g;
    g = 4'b0001 << i;
    return {g, col[i], 1'b1};
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] e;
    rst = 1'b1;
    req = '1;
    for (int n = 0; n < 2; n++) begin
      exp_q.push_back(BLANK);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, rgb, busy} !== e) begin
        fails++;
        $display("FAIL reset: got grant_rgb_busy=%b, expected %b", {grant, rgb, busy}, e);
      end
    end
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_basic;
    logic [7:0] e;
    do_reset();
    req = 4'b0100;
    exp_q.push_back(owned(2));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({grant, rgb, busy} !== e) begin
      fails++;
      $display("FAIL basic_grant: got grant_rgb_busy=%b, expected %b", {grant, rgb, busy}, e);
    end
    color[8:6] = 3'b110;
    exp_q.push_back({4'b0100, 3'b110, 1'b1});
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({grant, rgb, busy} !== e) begin
      fails++;
      $display("FAIL rgb_follow: got grant_rgb_busy=%b, expected %b", {grant, rgb, busy}, e);
    end
    color[8:6] = col[2];
    req = '0;
    exp_q.push_back(BLANK);
    exp_q.push_back(BLANK);
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, rgb, busy} !== e) begin
        fails++;
        $display("FAIL basic_release: got grant_rgb_busy=%b, expected %b", {grant, rgb, busy}, e);
      end
    end
  endtask

  task automatic test_rotation;
    logic [7:0] e;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < D; c++) exp_q.push_back(owned(k % N));
      if (k < 4) begin
        exp_q.push_back(BLANK);
        exp_q.push_back(BLANK);
      end
    end
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, rgb, busy} !== e) begin
        fails++;
        $display("FAIL rotation: got grant_rgb_busy=%b, expected %b", {grant, rgb, busy}, e);
      end
    end
  endtask

  task automatic test_lone;
    logic [7:0] e;
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 3 * D; c++) exp_q.push_back(owned(1));
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({grant, rgb, busy} !== e) begin
        fails++;
        $display("FAIL lone_hold: got grant_rgb_busy=%b, expected %b", {grant, rgb, busy}, e);
      end
    end
  endtask

  task automatic test_release;
    logic [7:0] e;
    do_reset();
    req = 4'b1100;
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 0) begin
        for (int c = 0; c < 5; c++) exp_q.push_back(owned(2));
      end else begin
        req = 4'b1000;
        exp_q.push_back(BLANK);
        exp_q.push_back(BLANK);
        exp_q.push_back(owned(3));
        exp_q.push_back(owned(3));
      end
      while (exp_q.size() != 0) begin
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({grant, rgb, busy} !== e) begin
          fails++;
          $display("FAIL release_handover: got grant_rgb_busy=%b, expected %b", {grant, rgb, busy}, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] e;
    do_reset();
    req = 4'b0010;
    for (int phase = 0; phase < 3; phase++) begin
      case (phase)
        0: begin
          exp_q.push_back(owned(1));
          exp_q.push_back(owned(1));
        end
        1: begin
          rst = 1'b1;
          exp_q.push_back(BLANK);
        end
        default: begin
          rst = 1'b0;
          req = 4'b1010;
          exp_q.push_back(owned(1));
        end
      endcase
      while (exp_q.size() != 0) begin
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({grant, rgb, busy} !== e) begin
          fails++;
          $display("FAIL reset_mid_grant: got grant_rgb_busy=%b, expected %b", {grant, rgb, busy}, e);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_preempt;
    logic [7:0] e;
    do_reset();
    req = 4'b1000;
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 0) begin
        exp_q.push_back(owned(3));
        exp_q.push_back(owned(3));
      end else begin
        req = 4'b1001;
`ifdef LED_ARBITER_PREEMPT_EN
        exp_q.push_back(BLANK);
        exp_q.push_back(BLANK);
        exp_q.push_back(owned(0));
`else
        for (int c = 0; c < D - 2; c++) exp_q.push_back(owned(3));
        exp_q.push_back(BLANK);
        exp_q.push_back(BLANK);
        exp_q.push_back(owned(0));
`endif
      end
      while (exp_q.size() != 0) begin
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({grant, rgb, busy} !== e) begin
          fails++;
          $display("FAIL preempt_req0: got grant_rgb_busy=%b, expected %b", {grant, rgb, busy}, e);
        end
      end
    end
    req = '0;
  endtask

  initial begin
    col[0] = 3'b101;
    col[1] = 3'b011;
    col[2] = 3'b010;
    col[3] = 3'b100;
    color  = {col[3], col[2], col[1], col[0]};
    rst    = 1'b1;
    req    = '0;
    #1;
    test_reset();
    test_basic();
    test_rotation();
    test_lone();
    test_release();
    test_reset_mid();
    test_preempt();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the RGB LED; legal range 2..8.
REQ-002 Parameter DWELL_TICKS, default 1000: maximum grant length in clk cycles when another requester is waiting; legal minimum 2.
REQ-003 Port clk  input  1  system clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port req  input  N_REQ  per-requester request, level-sensitive.
REQ-006 Port color  input  3*N_REQ  requester i color in bits [3i+2:3i], {R,G,B} order.
REQ-007 Port grant  output  N_REQ  one-hot grant, all zero when no owner.
REQ-008 Port rgb  output  3  LED drive.
REQ-009 Port busy  output  1  high while any requester holds a grant.

Function
REQ-010 The FSM SHALL be a 2-bit enum with states S_IDLE, S_GRANT and S_SWITCH; encoding 3 is illegal.
REQ-011 In S_IDLE, grant, rgb and busy SHALL be 0; if any req bit is high, the next state SHALL be S_GRANT, owned by the first requester found searching upward from ptr with wrap from N_REQ-1 to 0.
REQ-012 Request-to-grant latency SHALL be exactly 1 cycle: req sampled high in S_IDLE at edge t gives grant high after edge t+1.
REQ-013 In S_GRANT, grant SHALL be one-hot on the owner, busy SHALL be 1, and rgb SHALL equal the owner's color slice, combinationally following color changes.
REQ-014 Dwell timer: clear on entry to S_GRANT, increment by 1 per S_GRANT cycle, width $clog2(DWELL_TICKS+1), never wrap.
REQ-015 S_GRANT SHALL go to S_SWITCH when the owner's req is low (release); grant drops on the following edge.
REQ-016 S_GRANT SHALL go to S_SWITCH when timer == DWELL_TICKS-1 and any non-owner req is high (expiry).
REQ-017 At expiry with no other req pending, the FSM SHALL stay in S_GRANT and clear the timer, so a lone requester keeps the LED indefinitely.
REQ-018 On every S_GRANT-to-S_SWITCH transition, ptr SHALL load (owner+1) mod N_REQ.
REQ-019 S_SWITCH SHALL last exactly one cycle with grant=0, rgb=3'b000 and busy=0, then go to S_IDLE unconditionally; handover gap is 2 blank cycles.
REQ-020 Release and expiry in the same cycle SHALL be treated as release; ptr updates identically.
REQ-021 The illegal encoding SHALL drive rgb=3'b111 with grant=0 and SHALL return to S_IDLE on the next edge.
REQ-022 Requests arriving in S_SWITCH SHALL be evaluated only once the FSM is in S_IDLE.

Reset
REQ-023 While rst is high at a clock edge, the block SHALL load state=S_IDLE, ptr=0 and timer=0, giving grant=0, rgb=0 and busy=0 after that edge.
REQ-024 rst asserted mid-grant SHALL abort the grant with no S_SWITCH cycle; rst has priority over every transition.

Configuration
REQ-025 Macro LED_ARBITER_PREEMPT_EN SHALL select requester-0 preemption.
REQ-026 With the macro defined: in S_GRANT with owner != 0 and req[0] high, the next state SHALL be S_SWITCH and ptr SHALL load 0, so requester 0 wins the next S_IDLE arbitration regardless of timer.
REQ-027 With the macro undefined: requester 0 has no priority, and the preemption logic and its ptr path SHALL be absent.

Verification
REQ-028 Reset, then req=4'b0100 with color[8:6]=3'b010 -> grant=4'b0100 and rgb=3'b010 one cycle after req is sampled; busy=1.
REQ-029 req=4'b1111 held, DWELL_TICKS=8 -> grants rotate 0,1,2,3,0; each grant lasts 8 cycles, each separated by 2 cycles of rgb=0.
REQ-030 Only req[1] held for 3*DWELL_TICKS cycles -> grant stays 4'b0010 throughout, with no blank cycles.
REQ-031 Owner 2 drops req at cycle 5 with req[3] high -> 1 S_SWITCH cycle, 1 S_IDLE cycle, then grant=4'b1000.
REQ-032 rst pulsed during grant to requester 1 -> grant=0, rgb=0, busy=0 after that edge; next arbitration starts from ptr=0.
REQ-033 PREEMPT_EN defined, owner 3 with timer=1, req[0] rises -> grant=4'b0001 three cycles later; undefined -> requester 3 keeps the grant until DWELL_TICKS expires.
